dsm_decimator: RTL
==================

DSM_DECIMATOR -- requirements
Module: dsm_decimator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed output sample width.
REQ-002 SHALL have parameter DECIM_LOG2, default 6, log2 of decimation ratio R = 2**DECIM_LOG2; legal range 1..10.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_axis_data_tdata  input  1  delta-sigma bitstream (1 = +full scale, 0 = -full scale).
REQ-006 SHALL have port s_axis_data_tvalid  input  1  input bit valid.
REQ-007 SHALL have port s_axis_data_tready  output  1  input bit accepted when high with tvalid.
REQ-008 SHALL have port m_axis_data_tdata  output  WIDTH  signed decimated PCM sample.
REQ-009 SHALL have port m_axis_data_tvalid  output  1  sample valid.
REQ-010 SHALL have port m_axis_data_tready  input  1  downstream accept.

Function
REQ-011 SHALL implement a 3rd-order CIC (sinc3) decimator: three integrators at input rate, three combs (differential delay 1) at output rate.
REQ-012 SHALL map an accepted input bit to +1 (tdata=1) or -1 (tdata=0) before the first integrator.
REQ-013 SHALL size integrators/combs to B = 3*DECIM_LOG2+1 bits signed, two's-complement wrap permitted in integrators; WIDTH <= B required (elaboration error otherwise).
REQ-014 SHALL update integrators only on input handshake (tvalid && tready); no update otherwise.
REQ-015 SHALL count accepted beats 0..R-1 with a DECIM_LOG2-bit counter wrapping to 0.
REQ-016 SHALL, on the beat where counter = R-1, compute combs from the integrator values including that beat, update comb delay registers, and load the output register on the same edge.
REQ-017 SHALL assert m_axis_data_tvalid the cycle after the R-th accepted beat (latency 1 cycle from final contributing bit).
REQ-018 SHALL form output as comb3 arithmetic-shifted right by B-WIDTH bits; full scale (+/-R**3) thus maps to +/-2**(WIDTH-1).
REQ-019 SHALL hold m_axis_data_tdata/tvalid stable while tvalid high and tready low; clear tvalid after handshake unless a new sample loads on the same edge.
REQ-020 SHALL drive s_axis_data_tready = ~(counter = R-1 && m_axis_data_tvalid && ~m_axis_data_tready); no sample is ever dropped or overwritten.
REQ-021 SHALL, when output handshake and new sample load coincide, keep tvalid high with the new sample.
REQ-022 SHALL produce transient outputs for words 1-2 after reset; word 3 onward is fully settled.

Reset
REQ-023 SHALL on arst clear integrators, comb delays, counter, m_axis_data_tdata (0) and m_axis_data_tvalid (0).
REQ-024 SHALL drive s_axis_data_tready = 1 during and after reset.
REQ-025 SHALL, on reset mid-frame, discard partial accumulation; next frame starts with counter 0.

Configuration
REQ-026 SHALL support macro DSM_DECIMATOR_SAT_EN.
REQ-027 SHALL, with DSM_DECIMATOR_SAT_EN defined, clamp shifted result to [-2**(WIDTH-1), 2**(WIDTH-1)-1].
REQ-028 SHALL, without DSM_DECIMATOR_SAT_EN, take low WIDTH bits of shifted result (+full scale wraps to -2**(WIDTH-1)).

Verification (WIDTH=16, DECIM_LOG2=6, m_axis_data_tready=1 unless stated)
REQ-029 SHALL test all-ones input, SAT_EN defined -> word 3 onward = 32767; SAT_EN undefined -> word 3 onward = -32768.
REQ-030 SHALL test all-zeros input -> word 3 onward = -32768 both builds.
REQ-031 SHALL test alternating 1,0 bits -> word 3 onward = 0; pattern 1,1,1,0 repeating -> word 3 onward = 16384.
REQ-032 SHALL test m_axis_data_tready low for 200 cycles, input continuous -> s_axis_data_tready drops at beat 63 of frame 2, sample 1 held unchanged, no sample lost after tready returns.
REQ-033 SHALL test s_axis_data_tvalid gaps (1 of 3 cycles) -> sample sequence identical to gapless run; tvalid high exactly 1 cycle after each 64th accepted beat.
REQ-034 SHALL test arst pulse at beat 30 of a frame -> outputs 0/0 next cycle, next sample after 64 further beats, matches fresh-reset run.

Source files
------------

// File: rtl/dsm_decimator.sv
// Third-order CIC (sinc3) decimator turning a 1-bit delta-sigma stream into signed PCM.
// Optional build macro DSM_DECIMATOR_SAT_EN clamps the output instead of wrapping.
module dsm_decimator #(
    parameter int WIDTH      = 16,
    parameter int DECIM_LOG2 = 6
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready
);

    localparam int B = 3 * DECIM_LOG2 + 1;
`ifdef DSM_DECIMATOR_SAT_EN
    // One guard bit so that +R**3 stays distinguishable from -R**3 before clamping.
    localparam int CW = B + 1;
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`else
    localparam int CW = B;
`endif
    localparam int SH = B - WIDTH;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    generate
        if (WIDTH > B || WIDTH < 2) begin : g_bad_width
            $error("dsm_decimator: WIDTH must lie in 2..3*DECIM_LOG2+1");
        end
        if (DECIM_LOG2 < 1 || DECIM_LOG2 > 10) begin : g_bad_decim
            $error("dsm_decimator: DECIM_LOG2 must lie in 1..10");
        end
    endgenerate

    logic [DECIM_LOG2-1:0] r_cnt;
    logic signed [CW-1:0]  r_int1, r_int2, r_int3;
    logic signed [CW-1:0]  r_dly1, r_dly2, r_dly3;
    logic [WIDTH-1:0]      r_tdata;
    logic                  r_tvalid;

    logic                  w_in_hs, w_last, w_load;
    logic signed [CW-1:0]  w_step;
    logic signed [CW-1:0]  w_i1, w_i2, w_i3;
    logic signed [CW-1:0]  w_c1, w_c2, w_c3;
    logic signed [CW-1:0]  w_shift;
    logic [WIDTH-1:0]      w_out;
    logic                  w_unused_bits;

    // Stall the input only when the last beat would overwrite a sample still waiting downstream.
    assign w_last             = (r_cnt == CNT_LAST);
    assign s_axis_data_tready = arst | ~(w_last & r_tvalid & ~m_axis_data_tready);
    assign w_in_hs            = s_axis_data_tvalid & s_axis_data_tready;
    assign w_load             = w_in_hs & w_last;

    assign m_axis_data_tdata  = r_tdata;
    assign m_axis_data_tvalid = r_tvalid;
    assign w_unused_bits      = ^w_shift;

    // Integrator chain including the current beat, then comb chain evaluated on frame end.
    always_comb begin
        if (s_axis_data_tdata) begin
            w_step = {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_step = {CW{1'b1}};
        end
        w_i1    = r_int1 + w_step;
        w_i2    = r_int2 + w_i1;
        w_i3    = r_int3 + w_i2;
        w_c1    = w_i3 - r_dly1;
        w_c2    = w_c1 - r_dly2;
        w_c3    = w_c2 - r_dly3;
        w_shift = w_c3 >>> SH;
    end

    // Output scaling: clamp in the saturating build, plain truncation otherwise.
    always_comb begin
`ifdef DSM_DECIMATOR_SAT_EN
        if (w_shift > SAT_MAX) begin
            w_out = SAT_MAX[WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_out = SAT_MIN[WIDTH-1:0];
        end else begin
            w_out = w_shift[WIDTH-1:0];
        end
`else
        w_out = w_shift[WIDTH-1:0];
`endif
    end

    // Integrators, beat counter and comb delays advance only on accepted input beats.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_cnt  <= '0;
            r_int1 <= '0;
            r_int2 <= '0;
            r_int3 <= '0;
            r_dly1 <= '0;
            r_dly2 <= '0;
            r_dly3 <= '0;
        end else if (w_in_hs) begin
            r_cnt  <= r_cnt + 1'b1;
            r_int1 <= w_i1;
            r_int2 <= w_i2;
            r_int3 <= w_i3;
            if (w_last) begin
                r_dly1 <= w_i3;
                r_dly2 <= w_c1;
                r_dly3 <= w_c2;
            end
        end
    end

    // Output register: a new sample wins over a simultaneous downstream handshake.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= w_out;
            r_tvalid <= 1'b1;
        end else if (m_axis_data_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule
